// File: rtl/acq_accum.sv
`default_nettype none
// ============================================================================
// Module   : acq_accum
// Brief    : Multi-shot backscatter accumulator. Each laser pulse edge starts
//            one capture of record_len samples, summed into a 256 x 20 array.
// Revision : 1.0 - initial release
// ============================================================================
module acq_accum (
  input  logic        clock,
  input  logic        reset_async_n,
  input  logic        pulse_out,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic [7:0]  record_len,
  input  logic [7:0]  shots_n,
  input  logic [7:0]  rd_addr,
  output logic        acq_busy,
  output logic        acq_done,
  output logic [7:0]  shot_cnt,
  output logic        overrun,
  output logic [19:0] rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_WAIT_EDGE = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_pulse_d;
  logic [7:0]  r_len;
  logic [7:0]  r_shots;
  logic [7:0]  r_idx;
  logic [19:0] r_mem [0:255];

  logic        w_rise;
  logic        w_accept;
  logic        w_last;
  logic [7:0]  w_shot_next;
  logic [19:0] w_wdata;

  assign w_rise      = pulse_out & ~r_pulse_d;
  assign w_accept    = (r_state == ST_CAPTURE) && adc_valid;
  assign w_last      = (r_idx == (r_len - 8'd1));
  assign w_shot_next = shot_cnt + 8'd1;
  // First shot overwrites, so stale data from earlier runs never needs clearing
  assign w_wdata     = (shot_cnt == 8'd0) ? {8'd0, adc_data}
                                          : (r_mem[r_idx] + {8'd0, adc_data});

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem[r_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_async_n) begin
    if (!reset_async_n) begin
      r_state   <= ST_IDLE;
      r_pulse_d <= 1'b0;
      r_len     <= 8'd1;
      r_shots   <= 8'd1;
      r_idx     <= 8'd0;
      shot_cnt  <= 8'd0;
      overrun   <= 1'b0;
      acq_busy  <= 1'b0;
      acq_done  <= 1'b0;
      rd_data   <= 20'd0;
    end else begin
      r_pulse_d <= pulse_out;
      acq_done  <= 1'b0;
      rd_data   <= r_mem[rd_addr];
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_len    <= (record_len == 8'd0) ? 8'd1 : record_len;
            r_shots  <= (shots_n == 8'd0) ? 8'd1 : shots_n;
            shot_cnt <= 8'd0;
            overrun  <= 1'b0;
            r_idx    <= 8'd0;
            acq_busy <= 1'b1;
            r_state  <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_rise) begin
            overrun <= 1'b1;
          end
          if (adc_valid) begin
            if (w_last) begin
              r_idx    <= 8'd0;
              shot_cnt <= w_shot_next;
              if (w_shot_next == r_shots) begin
                r_state  <= ST_DONE;
                acq_busy <= 1'b0;
                acq_done <= 1'b1;
              end else begin
                r_state <= ST_WAIT_EDGE;
              end
            end else begin
              r_idx <= r_idx + 8'd1;
            end
          end
        end
        ST_WAIT_EDGE: begin
          if (w_rise) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/acq_accum.md
ACQ_ACCUM -- requirements
Module: acq_accum

Interface
REQ-001 SHALL have port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_async_n, input, 1: reset, asynchronous assert, active-low.
REQ-003 SHALL have port pulse_out, input, 1: laser pulse from the pulse generator; each rising edge marks one shot.
REQ-004 SHALL have port adc_data, input, 12: unsigned backscatter sample.
REQ-005 SHALL have port adc_valid, input, 1: adc_data valid this cycle.
REQ-006 SHALL have port record_len, input, 8: samples per shot; 0 treated as 1.
REQ-007 SHALL have port shots_n, input, 8: shots to accumulate per run; 0 treated as 1.
REQ-008 SHALL have port acq_busy, output, 1: run in progress; returned to the pulse generator.
REQ-009 SHALL have port acq_done, output, 1: one-cycle strobe at run completion.
REQ-010 SHALL have port shot_cnt, output, 8: shots completed in the current or last run.
REQ-011 SHALL have port overrun, output, 1: sticky flag, pulse edge arrived during CAPTURE.
REQ-012 SHALL have port rd_addr, input, 8: accumulator read index.
REQ-013 SHALL have port rd_data, output, 20: accumulated sum at rd_addr.

Function
REQ-014 SHALL hold a 256 x 20-bit accumulator array; 20 bits hold 255 x 4095 without overflow, so no saturation logic.
REQ-015 SHALL register pulse_out once; rise = pulse_out AND NOT pulse_out_d.
REQ-016 SHALL implement states IDLE, CAPTURE, WAIT_EDGE, DONE.
REQ-017 IDLE: on rise, latch record_len and shots_n (0->1), clear shot_cnt, overrun and sample index, go to CAPTURE next cycle.
REQ-018 Latched record_len/shots_n SHALL stay constant for the run; input changes mid-run have no effect.
REQ-019 CAPTURE: each cycle with adc_valid=1 SHALL write mem[idx] = adc_data when shot_cnt=0, otherwise mem[idx] + adc_data, then idx+1.
REQ-020 adc_valid=0 SHALL leave idx and memory unchanged; samples in IDLE, WAIT_EDGE and DONE SHALL be discarded.
REQ-021 On the accepted sample with idx = len-1: shot_cnt+1 and idx=0; go to DONE if the new shot_cnt equals shots_n, else WAIT_EDGE.
REQ-022 WAIT_EDGE: on rise go to CAPTURE; memory untouched.
REQ-023 A rise in CAPTURE SHALL be ignored for sequencing and SHALL set overrun; overrun clears only on reset or a new run start.
REQ-024 DONE SHALL last exactly one cycle with acq_done=1, then return to IDLE.
REQ-025 acq_busy SHALL be 1 in CAPTURE and WAIT_EDGE only, registered, asserted the cycle after the starting rise is detected.
REQ-026 Rise in the same cycle as DONE SHALL be ignored; a new run needs a rise seen in IDLE.
REQ-027 rd_data SHALL be registered mem[rd_addr], latency 1 cycle, valid in any state; content is defined only for idx < last latched len after a completed run.
REQ-028 Entries at idx >= len SHALL keep stale values; no clearing pass.

Reset
REQ-029 reset_async_n=0 SHALL immediately force IDLE, acq_busy=0, acq_done=0, shot_cnt=0, overrun=0, rd_data=0, pulse_out_d=0.
REQ-030 Accumulator memory SHALL NOT be reset; it is overwritten by the first shot of the next run.
REQ-031 Reset mid-run SHALL abort it with no acq_done; first rise after release starts a fresh run.

Verification
REQ-032 Single run: len=4, shots_n=3, adc_valid continuous, data 100,200,300,400 each shot -> acq_done once, shot_cnt=3, rd_data[0..3]=300,600,900,1200.
REQ-033 Gapped valid: len=3, shots_n=1, adc_valid toggling 1/0 with data 7,9,11 -> rd_data[0..2]=7,9,11; busy high until the third accepted sample.
REQ-034 Max sum: len=1, shots_n=255, adc_data=4095 -> rd_data[0]=1044225, no wrap.
REQ-035 Overrun: len=8, shots_n=2, second pulse_out rise issued mid-CAPTURE -> overrun=1, capture continues, run completes on the next rise in WAIT_EDGE.
REQ-036 Re-run without clearing: run with data 50, then run with data 5, same len=2, shots_n=1 -> rd_data[0..1]=5,5.
REQ-037 Reset mid-run: assert reset_async_n=0 during WAIT_EDGE of shot 2 -> acq_busy=0 same cycle, no acq_done, shot_cnt=0; next run behaves as REQ-032.
